uart_rx_fifo: RTL and testbench

//  UART receiver with a small elastic FIFO, directly upstream of the CPU bootloader's byte input.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo_if.sv | 9 +
 rtl/uart_rx_fifo_sync_fifo.sv | 50 +++++
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - receiver FSM states, oversampling constants and baud divider helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  function automatic int div_calc(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - received-byte valid/ready stream between uart_rx_fifo and its consumer
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// rtl/uart_rx_fifo_sync_fifo.sv - small synchronous FIFO with a registered head word
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [AW:0]      w_rd_nxt;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop_ok  = i_en && i_pop && !o_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign w_push_ok = i_en && i_push && (!o_full || w_pop_ok);
  assign w_rd_nxt  = r_rd + (AW+1)'(w_pop_ok);
  assign o_head    = r_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else if (i_en) begin
      if (w_push_ok) r_mem[r_wr[AW-1:0]] <= i_data;
      r_wr <= r_wr + (AW+1)'(w_push_ok);
      r_rd <= w_rd_nxt;
      // The head follows the read pointer; a push into a (now) empty FIFO bypasses the array.
      if (w_push_ok && (r_wr == w_rd_nxt)) r_head <= i_data;
      else if (w_pop_ok)                   r_head <= r_mem[w_rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling UART receiver feeding a byte FIFO; UART_RX_PARITY_EN selects 8E1
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_ce,
  input  logic           i_rx,
  input  logic           i_err_clr,
  output logic           o_frame_err,
  output logic           o_overrun,
  uart_rx_fifo_if.master m_rx
);
  localparam int DIV = div_calc(CLK_HZ, BAUD);
  localparam int TW  = $clog2(DIV);

  if (DIV < 2) begin : g_div_check
    $fatal(1, "uart_rx_fifo: CLK_HZ/(BAUD*16) must be at least 2");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "uart_rx_fifo: DEPTH must be a power of two in 2..16");
  end

  uart_state_e   r_state;
  uart_state_e   w_state_nxt;
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic [TW-1:0] r_div_cnt;
  logic [3:0]    r_sample;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          w_tick;
  logic          w_mid;
  logic          w_restart;
  logic          w_shift;
  logic          w_push;
  logic          w_ferr_set;
  logic          w_par_ok;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_ovr_set;
  logic [7:0]    w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_tick = i_ce && (r_div_cnt == TW'(DIV - 1));
  assign w_mid  = w_tick && (r_sample == 4'(MID_SAMPLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else if (i_ce) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!r_rx_sync) w_state_nxt = ST_START;
      ST_START:  if (w_mid) w_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (w_mid && r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (w_mid) w_state_nxt = ST_STOP;
`endif
      // Leaving at the stop mid-sample gives half a bit of slack for the next start edge.
      ST_STOP:   if (w_mid) w_state_nxt = r_rx_sync ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (r_rx_sync) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_restart  = 1'b0;
    w_shift    = 1'b0;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      ST_IDLE: w_restart = i_ce && !r_rx_sync;
      ST_DATA: w_shift   = w_mid;
      ST_STOP: begin
        w_push     = w_mid && r_rx_sync && w_par_ok;
        w_ferr_set = w_mid && !(r_rx_sync && w_par_ok);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sample  <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (i_ce) begin
      if (w_restart || w_tick) r_div_cnt <= '0;
      else                     r_div_cnt <= r_div_cnt + TW'(1);
      if (w_restart) begin
        r_sample  <= '0;
        r_bit_idx <= '0;
      end else begin
        if (w_tick)  r_sample  <= r_sample + 4'd1;
        if (w_shift) r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift) r_shift <= {r_rx_sync, r_shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_ok;

  // Even parity: data bits plus parity bit carry an even number of ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par_ok <= 1'b1;
    else if (i_ce) begin
      if (w_restart) r_par_ok <= 1'b1;
      else if (r_state == ST_PARITY && w_mid) r_par_ok <= (r_rx_sync == ^r_shift);
    end
  end
  assign w_par_ok = r_par_ok;
`else
  assign w_par_ok = 1'b1;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (i_ce),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (m_rx.rx_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign m_rx.rx_valid = !w_empty;
  assign m_rx.rx_data  = w_head;
  assign w_pop         = m_rx.rx_ready && !w_empty;
  assign w_ovr_set     = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else if (i_ce) begin
      if (w_ferr_set)     o_frame_err <= 1'b1;
      else if (i_err_clr) o_frame_err <= 1'b0;
      if (w_ovr_set)      o_overrun   <= 1'b1;
      else if (i_err_clr) o_overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (vector table, corner sequences, random frames)
module tb_uart_rx_fifo;
  localparam int CLK_HZ  = 3_200_000;
  localparam int BAUD    = 100_000;
  localparam int DEPTH   = 4;
  localparam int BIT_CLK = 32;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic ce      = 1'b1;
  logic rx      = 1'b1;
  logic err_clr = 1'b0;
  logic frame_err;
  logic overrun;

  uart_rx_fifo_if u_if ();

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ce        (ce),
    .i_rx        (rx),
    .i_err_clr   (err_clr),
    .o_frame_err (frame_err),
    .o_overrun   (overrun),
    .m_rx        (u_if)
  );

  always #5 clk = ~clk;

  int         n_vec   = 0;
  int         n_err   = 0;
  int         n_valid = 0;
  logic [7:0] q_got[$];

  // Inputs change just after the rising edge, so the falling edge sees what the next edge consumes.
  always @(negedge clk) begin
    if (u_if.rx_valid) n_valid++;
    if (u_if.rx_valid && u_if.rx_ready && ce) q_got.push_back(u_if.rx_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int idx);
    if (idx < q_got.size()) return q_got[idx];
    return 8'hxx;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_pb(input logic [7:0] b, input logic pbit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(pbit);
    send_bit(1'b1);
  endtask
`endif

  task automatic pulse_clr();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_n;
    logic       exp_ferr;
  } vec_t;

  initial begin
    vec_t       vecs[6];
    int         base;
    int         vbase;
    logic [7:0] pb;
    logic [7:0] q_exp[$];
    logic [7:0] q_mod[$];
    logic       e_ferr;
    logic       e_ovr;
    logic [7:0] rb;
    logic       good;
    logic       rdy;

    vecs[0] = '{8'hA5, 1'b1, 1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 0, 1'b1};
    vecs[5] = '{8'h55, 1'b1, 1, 1'b0};

    u_if.rx_ready = 1'b1;
    wait_clk(3);
    check("reset_valid", 32'(u_if.rx_valid), 0);
    check("reset_data", 32'(u_if.rx_data), 0);
    check("reset_ferr", 32'(frame_err), 0);
    check("reset_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    wait_clk(40);

    for (int v = 0; v < 6; v++) begin
      base  = q_got.size();
      vbase = n_valid;
      send_frame(vecs[v].data, vecs[v].stop);
      wait_clk(8);
      check($sformatf("vec%0d_count", v), 32'(q_got.size() - base), 32'(vecs[v].exp_n));
      check($sformatf("vec%0d_valid_cycles", v), 32'(n_valid - vbase), 32'(vecs[v].exp_n));
      if (vecs[v].exp_n == 1) check($sformatf("vec%0d_byte", v), 32'(got_at(base)), 32'(vecs[v].data));
      check($sformatf("vec%0d_ferr", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovr", v), 32'(overrun), 0);
      pulse_clr();
    end

    u_if.rx_ready = 1'b0;
    base = q_got.size();
    for (int b = 1; b <= 6; b++) begin
      send_frame(8'(b), 1'b1);
      if (b == 4) check("fill_no_ovr", 32'(overrun), 0);
      if (b == 5) check("fifth_ovr", 32'(overrun), 1);
    end
    wait_clk(4);
    u_if.rx_ready = 1'b1;
    wait_clk(10);
    check("drain_count", 32'(q_got.size() - base), 4);
    for (int k = 0; k < 4; k++) check($sformatf("drain%0d", k), 32'(got_at(base + k)), 32'(k + 1));
    check("ovr_sticky", 32'(overrun), 1);
    pulse_clr();
    check("ovr_clr", 32'(overrun), 0);

    base = q_got.size();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    wait_clk(40 * BIT_CLK);
    check("break_ferr", 32'(frame_err), 1);
    check("break_no_byte", 32'(q_got.size() - base), 0);
    pulse_clr();
    wait_clk(10 * BIT_CLK);
    check("break_single_err", 32'(frame_err), 0);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("break_release", 32'(frame_err), 0);
    send_frame(8'h3C, 1'b1);
    wait_clk(8);
    check("after_break_count", 32'(q_got.size() - base), 1);
    check("after_break_byte", 32'(got_at(base)), 32'h3C);

    base = q_got.size();
    rx = 1'b0;
    wait_clk(4);
    rx = 1'b1;
    wait_clk(3 * BIT_CLK);
    check("glitch_no_byte", 32'(q_got.size() - base), 0);
    check("glitch_no_ferr", 32'(frame_err), 0);
    send_frame(8'h3C, 1'b0);
    wait_clk(8);
    check("ferr_set", 32'(frame_err), 1);
    ce = 1'b0;
    err_clr = 1'b1;
    wait_clk(3);
    check("clr_needs_ce", 32'(frame_err), 1);
    ce = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    check("clr_next_cycle", 32'(frame_err), 0);

    base = q_got.size();
    ce = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_clk(8);
    ce = 1'b1;
    wait_clk(40);
    check("ce_freeze_rx", 32'(q_got.size() - base), 0);
    u_if.rx_ready = 1'b0;
    send_frame(8'h99, 1'b1);
    wait_clk(4);
    ce = 1'b0;
    u_if.rx_ready = 1'b1;
    wait_clk(10);
    check("ce_hold_valid", 32'(u_if.rx_valid), 1);
    check("ce_hold_data", 32'(u_if.rx_data), 32'h99);
    check("ce_hold_nopop", 32'(q_got.size() - base), 0);
    ce = 1'b1;
    wait_clk(4);
    check("ce_resume_pop", 32'(got_at(base)), 32'h99);

    u_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0);
    wait_clk(8);
    check("pre_rst_valid", 32'(u_if.rx_valid), 1);
    check("pre_rst_ferr", 32'(frame_err), 1);
    pb = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(pb[i]);
    rx = pb[4];
    wait_clk(16);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(u_if.rx_valid), 0);
    check("rst_async_data", 32'(u_if.rx_data), 0);
    check("rst_async_ferr", 32'(frame_err), 0);
    rx = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(64);
    base = q_got.size();
    u_if.rx_ready = 1'b1;
    wait_clk(4);
    check("rst_fifo_empty", 32'(q_got.size() - base), 0);
    send_frame(8'h7E, 1'b1);
    wait_clk(8);
    check("post_rst_count", 32'(q_got.size() - base), 1);
    check("post_rst_byte", 32'(got_at(base)), 32'h7E);
    check("post_rst_ferr", 32'(frame_err), 0);

`ifdef UART_RX_PARITY_EN
    base = q_got.size();
    send_frame_pb(8'h07, 1'b0);
    wait_clk(8);
    check("par_bad_ferr", 32'(frame_err), 1);
    check("par_bad_no_byte", 32'(q_got.size() - base), 0);
    pulse_clr();
    send_frame_pb(8'h07, 1'b1);
    wait_clk(8);
    check("par_good_count", 32'(q_got.size() - base), 1);
    check("par_good_byte", 32'(got_at(base)), 32'h07);
    check("par_good_ferr", 32'(frame_err), 0);
`endif

    // Random frames: a bad stop bit loses the byte; with ready low bytes queue until DEPTH, then overrun.
    pulse_clr();
    wait_clk(10);
    base   = q_got.size();
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      rb   = 8'($urandom);
      good = ($urandom % 6) != 0;
      rdy  = ($urandom % 3) == 0;
      u_if.rx_ready = rdy;
      if (rdy) begin
        while (q_mod.size() > 0) q_exp.push_back(q_mod.pop_front());
        if (good) q_exp.push_back(rb);
      end else if (good) begin
        if (q_mod.size() < DEPTH) q_mod.push_back(rb);
        else e_ovr = 1'b1;
      end
      if (!good) e_ferr = 1'b1;
      send_frame(rb, good);
      wait_clk(good ? $urandom_range(0, 20) : $urandom_range(4, 20));
    end
    u_if.rx_ready = 1'b1;
    wait_clk(10);
    while (q_mod.size() > 0) q_exp.push_back(q_mod.pop_front());
    check("rand_count", 32'(q_got.size() - base), 32'(q_exp.size()));
    for (int k = 0; k < q_exp.size(); k++) check($sformatf("rand_byte%0d", k), 32'(got_at(base + k)), 32'(q_exp[k]));
    check("rand_ferr", 32'(frame_err), 32'(e_ferr));
    check("rand_ovr", 32'(overrun), 32'(e_ovr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
